// File: rtl/alu_cmd_sequencer.sv
// Command front end for the 16-bit aluu datapath: buffers requests in a FIFO, issues them one at a
// time to the registered ALU, returns tagged results and owns the architectural status register.
module alu_cmd_sequencer #(
    parameter int         DEPTH       = 4,
    parameter logic [4:0] STATUS_INIT = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        alu_rst,
    output logic [4:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_status,
    input  logic [15:0] alu_c0,
    input  logic [15:0] alu_c1,
    input  logic [4:0]  alu_status_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [4:0]  res_op,
    output logic [15:0] res_c0,
    output logic [15:0] res_c1,
    output logic [4:0]  res_status,
    output logic [4:0]  status,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_fifo_op [DEPTH];
    logic [15:0] r_fifo_a  [DEPTH];
    logic [15:0] r_fifo_b  [DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        r_cmd_en, r_alu_rst;
    logic [4:0]  r_alu_op, r_res_op, r_res_status, r_status;
    logic [15:0] r_alu_a, r_alu_b, r_res_c0, r_res_c1;
    logic        r_res_valid;
    logic        w_empty, w_full, w_push, w_pop, w_capture, w_res_accept;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign cmd_ready = r_cmd_en & ~w_full;
    assign w_push    = cmd_valid & cmd_ready;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_res_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                w_capture   = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_res_accept = 1'b1;
                    w_pop        = !w_empty;
                    w_state_nxt  = w_empty ? S_IDLE : S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // cmd_ready opens one cycle after reset release; the ALU reset trails it by one more cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cmd_en  <= 1'b0;
            r_alu_rst <= 1'b1;
        end else begin
            r_cmd_en  <= 1'b1;
            r_alu_rst <= ~r_cmd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr[AW-1:0]] <= cmd_op;
            r_fifo_a[r_wr_ptr[AW-1:0]]  <= cmd_a;
            r_fifo_b[r_wr_ptr[AW-1:0]]  <= cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_res_valid  <= 1'b0;
            r_res_op     <= '0;
            r_res_c0     <= '0;
            r_res_c1     <= '0;
            r_res_status <= '0;
            r_status     <= STATUS_INIT;
        end else begin
            if (w_pop) begin
                r_alu_op <= r_fifo_op[r_rd_ptr[AW-1:0]];
                r_alu_a  <= r_fifo_a[r_rd_ptr[AW-1:0]];
                r_alu_b  <= r_fifo_b[r_rd_ptr[AW-1:0]];
            end
            if (w_capture) begin
                r_res_valid  <= 1'b1;
                r_res_op     <= r_alu_op;
                r_res_c0     <= alu_c0;
                r_res_c1     <= alu_c1;
                r_res_status <= alu_status_out;
                r_status     <= alu_status_out;
            end else if (w_res_accept) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign alu_rst    = r_alu_rst;
    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_status = r_status;
    assign status     = r_status;
    assign res_valid  = r_res_valid;
    assign res_op     = r_res_op;
    assign res_c0     = r_res_c0;
    assign res_c1     = r_res_c1;
    assign res_status = r_res_status;
    assign busy       = ~w_empty | (r_state != S_IDLE);

endmodule
